// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the data-memory arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, GNT_P, GNT_L)
//   - REQ_P/REQ_L : requester ids, also the encoding of the round-robin
//                   last-grant flop
//   - WAIT_DEFAULT: default memory access cycles per transaction
//   - rr_pick     : winner selection for round-robin arbitration
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_P = 2'd1,
    GNT_L = 2'd2
  } arb_state_e;

  localparam logic REQ_P = 1'b0;
  localparam logic REQ_L = 1'b1;

  localparam int WAIT_DEFAULT = 2;

  // Returns the requester id to grant. A lone request always wins; on a
  // tie the port that did not receive the previous grant wins.
  function automatic logic rr_pick(input logic p_req, input logic l_req,
                                   input logic last_grant);
    if (p_req && l_req) return (last_grant == REQ_P) ? REQ_L : REQ_P;
    return l_req ? REQ_L : REQ_P;
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: access-cycle counter for the arbiter.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear (held while the arbiter is idle)
//   en_i       : count one access cycle
//   done_o     : count has reached WAIT-1, i.e. this is the final cycle
module arb_wait_counter #(
  parameter int WAIT = 2,
  parameter int CW   = $clog2(WAIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [CW-1:0] LAST = CW'(WAIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the pipeline MEM
// stage (port P) and a loader/debug port (port L).
//   P side : p_req/p_we/p_addr/p_wdata in, p_rdata out, p_stall out
//   L side : l_req/l_we/l_addr/l_wdata in, l_rdata out, l_ack (1-cycle) out
//   Memory : m_en/m_we/m_addr/m_wdata out, m_rdata in (combinational)
//   busy   : arbiter is not idle
// Each access takes WAIT cycles after the grant; the arbiter always spends
// one IDLE cycle between accesses.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration;
// otherwise P has fixed priority over L.
module dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT = WAIT_DEFAULT,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic [DW-1:0] p_rdata,
  output logic          p_stall,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic [DW-1:0] l_rdata,
  output logic          l_ack,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  arb_state_e    state_q;
  logic          acc_we_q;
  logic [AW-1:0] acc_addr_q;
  logic [DW-1:0] acc_wdata_q;
  logic [DW-1:0] p_rdata_q;
  logic [DW-1:0] l_rdata_q;

  logic cnt_done, done, gnt_p, gnt_l, win_l;

  assign busy  = (state_q != IDLE);
  assign gnt_p = (state_q == GNT_P);
  assign gnt_l = (state_q == GNT_L);
  // The counter's compare is only meaningful while a grant is active.
  assign done  = busy & cnt_done;

  arb_wait_counter #(.WAIT(WAIT)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (~busy),
    .en_i   (busy),
    .done_o (cnt_done)
  );

`ifdef DMEM_ARB_RR_EN
  logic last_grant_q;
  assign win_l = rr_pick(p_req, l_req, last_grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               last_grant_q <= REQ_L;
    else if (state_q == IDLE && (p_req | l_req)) last_grant_q <= win_l;
  end
`else
  // Fixed priority: L only wins when P is not asking.
  assign win_l = ~p_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
      p_rdata_q   <= '0;
      l_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (p_req | l_req) begin
            state_q     <= win_l ? GNT_L : GNT_P;
            acc_we_q    <= win_l ? l_we    : p_we;
            acc_addr_q  <= win_l ? l_addr  : p_addr;
            acc_wdata_q <= win_l ? l_wdata : p_wdata;
          end
        end
        GNT_P, GNT_L: begin
          if (done) begin
            state_q <= IDLE;
            // Stores leave the read-data hold registers untouched.
            if (!acc_we_q) begin
              if (gnt_p) p_rdata_q <= m_rdata;
              else       l_rdata_q <= m_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory bus is forced to zero while idle.
  assign m_en    = busy;
  assign m_we    = done & acc_we_q;
  assign m_addr  = busy ? acc_addr_q  : '0;
  assign m_wdata = busy ? acc_wdata_q : '0;

  // Done cycle passes memory data straight through so the requester sees it
  // in the same cycle it is released; afterwards the hold register serves.
  assign p_stall = p_req & ~(gnt_p & done);
  assign p_rdata = (gnt_p & done) ? m_rdata : p_rdata_q;
  assign l_ack   = gnt_l & done;
  assign l_rdata = l_ack ? m_rdata : l_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between the pipeline MEM stage (port P) and a loader/debug port (port L). It sequences multi-cycle memory accesses with a configurable wait-state count. It stalls the pipeline until its access completes and returns a one-cycle acknowledge to the loader. It sits between the memory stage and the data memory, replacing the direct stage-to-memory connection.

## Interface
Parameters:
- WAIT, default 2: memory access cycles per transaction; legal values ≥1.
- AW, default 32: address width.
- DW, default 32: data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p_req  in  1  pipeline access request; held stable while p_stall=1.
- p_we  in  1  pipeline write enable (1=store, 0=load).
- p_addr  in  AW  pipeline address.
- p_wdata  in  DW  pipeline store data.
- p_rdata  out  DW  pipeline load data.
- p_stall  out  1  pipeline stall request.
- l_req  in  1  loader request; level, held until l_ack.
- l_we  in  1  loader write enable.
- l_addr  in  AW  loader address.
- l_wdata  in  DW  loader write data.
- l_rdata  out  DW  loader read data.
- l_ack  out  1  loader completion pulse, 1 cycle.
- m_en  out  1  memory access active.
- m_we  out  1  memory write strobe.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data; combinational from m_addr.
- busy  out  1  high whenever state≠IDLE.

## Operation
- FSM states: IDLE, GNT_P, GNT_L.
- IDLE
  - If any request is pending, arbitrate and latch the winner's we/addr/wdata into access registers.
  - Clear cnt.
  - Move to GNT_P or GNT_L.
  - Default arbitration is fixed priority: P beats L.
- GNT_x
  - Drive m_en=1 and m_addr/m_wdata from the access registers.
  - cnt increments each cycle.
  - The final cycle is the cycle with cnt==WAIT-1: "done".
- Done cycle
  - m_we=latched we, and only in this cycle, so each write is issued exactly once.
  - Read data is m_rdata.
  - The winner's rdata register captures m_rdata at the closing edge.
  - Return to IDLE.
- p_stall = p_req & ~(state==GNT_P & done).
- p_rdata = m_rdata during the GNT_P done cycle; otherwise it holds the last completed P read.
  - A store leaves the rdata register unchanged.
- l_ack=1 only in the GNT_L done cycle.
- l_rdata follows the same pass-through/hold rule as p_rdata.
- In IDLE: m_en=0, m_we=0, m_addr=0, m_wdata=0.
- A request arriving while the other port is granted waits in IDLE arbitration after completion; it is never aborted.
- Loader must drop l_req the cycle after l_ack, otherwise the still-high l_req is taken as a new request.

## Timing
- Request seen in IDLE at cycle N: access occupies cycles N+1..N+WAIT, and done is cycle N+WAIT.
- The pipeline stalls cycles N..N+WAIT-1 (WAIT stall cycles) and advances at the edge ending N+WAIT.
- Back-to-back: after done, state is IDLE for at least one cycle before the next grant. Throughput is one access per WAIT+1 cycles.
- WAIT=1: done is the first GNT cycle; the pipeline sees 1 stall cycle.
- Reset values: state=IDLE, cnt=0, all access and rdata registers 0.
  - Outputs: p_stall=p_req, l_ack=0, m_en=0, m_we=0, busy=0.
- Reset mid-access: the access is aborted immediately, no write is issued, and rdata is cleared.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - A last_grant flop, reset to L, updates on each grant.
  - On a simultaneous P/L request in IDLE, grant the port not granted last.
  - A single request is granted regardless of last_grant.
- DMEM_ARB_RR_EN undefined: fixed P priority, no last_grant flop. L may starve under continuous P traffic.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, GNT_P, GNT_L);
  - requester id constants (REQ_P=0, REQ_L=1);
  - the default WAIT.
- Sub-module arb_wait_counter:
  - $clog2(WAIT+1)-bit counter with clear/enable;
  - asserts done when count==WAIT-1.

## Test plan
- WAIT=2; P load addr 0x10, mem holds 0xDEADBEEF -> p_stall high 2 cycles; p_rdata=0xDEADBEEF in done cycle, held afterwards.
- P store 0x20←0x1234 -> m_we high exactly 1 cycle (done); a later read of 0x20 returns 0x1234.
- L write 0x40←0xA5A5 then read 0x40 -> one l_ack pulse per access; l_rdata=0xA5A5.
- P and L request the same cycle.
  - Macro off: P granted first, L acks WAIT+1 cycles later.
  - Macro on, after a prior P grant: L granted first.
- Assert rst_n low during the GNT_P cycle of a store -> no m_we pulse; state IDLE, busy=0, p_rdata=0.
- WAIT=1 with continuous P requests -> p_stall pattern 1,0 repeating; one access per 2 cycles.
